// File: rtl/fb_write_arbiter_pkg.sv
// fb_pkg: shared frame-buffer types, widths and round-robin helper
package fb_pkg;
    localparam int FB_ADDR_WIDTH = 19;
    localparam int FB_OVR_CNT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, START, RENDER, DONE} fb_arb_state_t;
    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic rr_last);
        return (valid == 2'b11) ? (rr_last ? 2'b01 : 2'b10) : valid;
    endfunction
endpackage

// File: rtl/fb_write_arbiter_if.sv
// fb_write_arbiter_if: requester write handshake plus frame_buffer write port
interface fb_write_arbiter_if import fb_pkg::*; #(parameter int ADDR_WIDTH = FB_ADDR_WIDTH);
    logic [1:0]                 req_valid;
    logic [1:0][ADDR_WIDTH-1:0] req_addr;
    logic [1:0]                 req_data;
    logic [1:0]                 req_done;
    logic [1:0]                 req_ready;
    logic                       wr_en;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic                       wr_data;
    modport master (
        output req_valid, req_addr, req_data, req_done,
        input  req_ready, wr_en, wr_addr, wr_data
    );
    modport slave (
        input  req_valid, req_addr, req_data, req_done,
        output req_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_write_arbiter_rr.sv
// rr_arbiter2: 2-way round-robin grant; rr_last remembers the last winner
module rr_arbiter2 import fb_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic rr_last;
    assign grant = en ? rr_pick(valid, rr_last) : 2'b00;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_last <= 1'b1;
        else if (|grant) rr_last <= grant[1];
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the frame_buffer write port and sequences frames
module fb_write_arbiter import fb_pkg::*; #(
    parameter int ADDR_WIDTH    = FB_ADDR_WIDTH,
    parameter int OVR_CNT_WIDTH = FB_OVR_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     swap,
    fb_write_arbiter_if.slave        bus,
    output logic                     frame_start,
    output logic                     frame_done,
    output logic                     overrun,
    output logic [OVR_CNT_WIDTH-1:0] overrun_cnt
);
    fb_arb_state_t         state_q, state_d;
    logic [1:0]            done_q, done_d, grant;
    logic                  hs, gi, ovr_hit, wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  wr_data_q;
    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ce && state_q == RENDER),
        .valid (bus.req_valid & ~done_q),
        .grant (grant)
    );
    assign bus.req_ready = grant;
    assign hs            = |grant;
    assign gi            = grant[1];
    // a write registered just before ce dropped is held back until ce returns
    assign bus.wr_en     = wr_en_q & ce;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        ovr_hit     = 1'b0;
        frame_done  = 1'b0;
        frame_start = ce && state_q == START;
        case (state_q)
            IDLE:   state_d = swap ? START : IDLE;
            START:  begin
                done_d  = 2'b00;
                state_d = RENDER;
            end
            RENDER: begin
                done_d = done_q | bus.req_done;
                if (swap) begin
                    ovr_hit = 1'b1;
                    state_d = START;
                end else if (&done_q && !hs) begin
                    frame_done = ce;
                    state_d    = DONE;
                end
            end
            DONE:   state_d = swap ? START : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            done_q      <= 2'b00;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else if (ce) begin
            state_q <= state_d;
            done_q  <= done_d;
            wr_en_q <= hs;
            if (hs) begin
                wr_addr_q <= bus.req_addr[gi];
                wr_data_q <= bus.req_data[gi];
            end
            if (ovr_hit) begin
                overrun     <= 1'b1;
                overrun_cnt <= &overrun_cnt ? overrun_cnt : overrun_cnt + OVR_CNT_WIDTH'(1);
            end
        end
    end
endmodule
